// File: rtl/red_nibble_seq_if.sv
// Purpose : request/response bundle between the execute-stage issue logic and
//           the signed nibble-reduction unit.
// Signals : start        - request, sampled by the unit only while idle
//           op_a, op_b   - operands, sampled with start
//           busy         - unit is accumulating or presenting a result
//           done         - one-cycle pulse, result valid
//           result       - sign-extended nibble sum, held until the next done
// Modports: master (issuer), slave (reduction unit)
interface red_nibble_seq_if #(
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;

   modport master (
      output start, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, op_a, op_b,
      output busy, done, result
   );
endinterface

// File: rtl/red_nibble_seq.sv
// Purpose : multi-cycle signed nibble reduction. Each ACCUM cycle adds one
//           sign-extended nibble of op_a and one of op_b (LSB nibble first)
//           into an ACC_W-bit accumulator; the final sum is sign-extended to
//           DATA_W and presented with a one-cycle done pulse.
// Ports   : clk  - clock, all state updates on the rising edge
//           rst  - synchronous active-high reset
//           io   - red_nibble_seq_if.slave (start/op_a/op_b in,
//                  busy/done/result out, all outputs registered)
// Config  : RED_EARLY_TERM_EN - when defined, the operation finishes after the
//           step whose higher latched nibbles of both operands are all zero.
//           When undefined, every operation takes DATA_W/4 ACCUM cycles and
//           no zero-detect logic is built.
module red_nibble_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 7
) (
   input  logic             clk,
   input  logic             rst,
   red_nibble_seq_if.slave  io
);

   localparam int unsigned NIB_N   = DATA_W / 4;
   localparam int unsigned CNT_W   = (NIB_N > 1) ? $clog2(NIB_N) : 1;
   localparam int unsigned EXT_W   = ACC_W - 4;
   localparam int unsigned RES_EXT = DATA_W - ACC_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DATA_W-1:0]  result_q, result_d;

   logic [3:0]         a_nib;
   logic [3:0]         b_nib;
   logic [ACC_W-1:0]   acc_next;
   logic               last_step;

   // Datapath: current nibble pair and the accumulator after this step.
   always_comb begin
      a_nib    = a_q[{cnt_q, 2'b00} +: 4];
      b_nib    = b_q[{cnt_q, 2'b00} +: 4];
      acc_next = acc_q
               + {{EXT_W{a_nib[3]}}, a_nib}
               + {{EXT_W{b_nib[3]}}, b_nib};
   end

`ifdef RED_EARLY_TERM_EN
   logic upper_zero;

   // All latched nibbles above the current index are zero in both operands.
   always_comb begin
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < NIB_N; i++) begin
         if ((CNT_W'(i) > cnt_q) &&
             ((a_q[4*i +: 4] != 4'd0) || (b_q[4*i +: 4] != 4'd0))) begin
            upper_zero = 1'b0;
         end
      end
   end

   assign last_step = (cnt_q == CNT_W'(NIB_N - 1)) || upper_zero;
`else
   assign last_step = (cnt_q == CNT_W'(NIB_N - 1));
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (io.start) state_d = S_ACCUM;
         S_ACCUM: if (last_step) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values; busy/done are registered from state_d.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (io.start) begin
               a_d   = io.op_a;
               b_d   = io.op_b;
               acc_d = '0;
               cnt_d = '0;
            end
         end
         S_ACCUM: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               result_d = {{RES_EXT{acc_next[ACC_W-1]}}, acc_next};
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign io.busy   = busy_q;
   assign io.done   = done_q;
   assign io.result = result_q;

endmodule
